// File: rtl/orange_sweep_capture.sv
`timescale 1ns/1ps
// Exhaustive-sweep engine: walks vec through every input combination, samples y_in
// on the last dwell cycle of each vector and scores the captured truth table.
module orange_sweep_capture #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned DWELL = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   exp_table,
    input  logic                   y_in,
    output logic [N_IN-1:0]        vec,
    output logic                   vec_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_cnt,
    output logic [N_IN:0]          mism_cnt,
    output logic [N_IN-1:0]        first_mism,
    output logic                   pass
);

    localparam int unsigned DEPTH = 1 << N_IN;
    localparam int unsigned CW    = N_IN + 1;
    localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(DEPTH - 1);
    localparam logic [DW-1:0]   LAST_DWELL = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [DW-1:0]        dwell;
    logic [DEPTH-1:0]     exp_q;

    logic start_ok_c;
    logic mismatch_c;

    // start is only honoured outside RUN, and a coincident abort drops it
    assign start_ok_c = start && !abort && (state != RUN);
    assign mismatch_c = y_in ^ exp_q[vec];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dwell      <= '0;
            exp_q      <= '0;
            vec        <= '0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            table_out  <= '0;
            ones_cnt   <= '0;
            mism_cnt   <= '0;
            first_mism <= '0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok_c) begin
                        state      <= RUN;
                        dwell      <= '0;
                        exp_q      <= exp_table;
                        vec        <= '0;
                        vec_valid  <= 1'b1;
                        busy       <= 1'b1;
                        aborted    <= 1'b0;
                        table_out  <= '0;
                        ones_cnt   <= '0;
                        mism_cnt   <= '0;
                        first_mism <= '0;
                        pass       <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // abort beats a same-cycle sample; partial results are kept
                        state     <= IDLE;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                    end else if (dwell == LAST_DWELL) begin
                        table_out[vec] <= y_in;
                        ones_cnt       <= ones_cnt + CW'(y_in);
                        if (mismatch_c) begin
                            mism_cnt <= mism_cnt + CW'(1);
                            if (mism_cnt == '0) begin
                                first_mism <= vec;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            state     <= DONE;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (mism_cnt == '0) && !mismatch_c;
                        end else begin
                            vec   <= vec + N_IN'(1);
                            dwell <= '0;
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
